bcd_declet_packer: RTL and testbench

//  Stream controller for the dpd_pack encoder. Takes BCD digits one per cycle, most-significant first,

---
 rtl/dpd_stream_pkg.sv | 16 +
 rtl/dpd_pack.sv | 27 ++
 rtl/bcd_declet_packer.sv | 138 +++++++++++++
 tb/tb_bcd_declet_packer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpd_stream_pkg.sv
// Shared widths, limits and group-fill states for the BCD-to-DPD streaming packer.
package dpd_stream_pkg;

    localparam int DIGIT_W  = 4;
    localparam int DECLET_W = 10;

    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    // Number of digits already held in the current group.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } grp_cnt_t;

endpackage

// File: rtl/dpd_pack.sv
// Combinational densely-packed-decimal encoder: three BCD digits -> one 10-bit declet.
// Digit MSBs select the layout; digits above 9 are encoded from their raw bits.
module dpd_pack
    import dpd_stream_pkg::*;
(
    input  logic [DIGIT_W-1:0]  d2,
    input  logic [DIGIT_W-1:0]  d1,
    input  logic [DIGIT_W-1:0]  d0,
    output logic [DECLET_W-1:0] dpd
);

    // Select the declet layout from the "large digit" flags of the three digits.
    always_comb begin
        dpd = '0;
        case ({d2[3], d1[3], d0[3]})
            3'b000:  dpd = {d2[2:0], d1[2:0], 1'b0, d0[2:0]};
            3'b001:  dpd = {d2[2:0], d1[2:0], 1'b1, 2'b00, d0[0]};
            3'b010:  dpd = {d2[2:0], d0[2:1], d1[0], 1'b1, 2'b01, d0[0]};
            3'b011:  dpd = {d2[2:0], 2'b10, d1[0], 1'b1, 2'b11, d0[0]};
            3'b100:  dpd = {d0[2:1], d2[0], d1[2:0], 1'b1, 2'b10, d0[0]};
            3'b101:  dpd = {d1[2:1], d2[0], 2'b01, d1[0], 1'b1, 2'b11, d0[0]};
            3'b110:  dpd = {d0[2:1], d2[0], 2'b00, d1[0], 1'b1, 2'b11, d0[0]};
            default: dpd = {2'b00, d2[0], 2'b11, d1[0], 1'b1, 2'b11, d0[0]};
        endcase
    end

endmodule

// File: rtl/bcd_declet_packer.sv
// Streams BCD digits (MS first) into groups of three and emits DPD declets over valid/ready.
// Short final groups are left-zero-extended; groups holding a digit above 9 are flagged.
//
// state | meaning
// EMPTY | no digits of the current group held
// ONE   | one digit held in s0
// TWO   | two digits held in s1,s0; next accept closes the group
module bcd_declet_packer
    import dpd_stream_pkg::*;
#(
    parameter int IDX_W    = 8,
    parameter bit ERR_ZERO = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dig_valid,
    input  logic [DIGIT_W-1:0]  dig_data,
    input  logic                dig_last,
    output logic                dig_ready,
    output logic                dec_valid,
    output logic [DECLET_W-1:0] dec_data,
    output logic [1:0]          dec_ndig,
    output logic                dec_last,
    output logic                dec_err,
    output logic [IDX_W-1:0]    dec_idx,
    input  logic                dec_ready,
    output logic                err_sticky,
    input  logic                clr_err
);

    // Only two digit stages are kept: the third digit of a group is packed straight
    // from dig_data on the accepting edge, so an s2 stage would never be read.
    logic [DIGIT_W-1:0]  s1;
    logic [DIGIT_W-1:0]  s0;
    grp_cnt_t            cnt;
    grp_cnt_t            cnt_next;
    logic                grp_err;
    logic [IDX_W-1:0]    idx;
    logic                accept;
    logic                grp_done;
    logic                grp_err_all;
    logic [DECLET_W-1:0] packed_dpd;

    dpd_pack u_dpd_pack (
        .d2  (s1),
        .d1  (s0),
        .d0  (dig_data),
        .dpd (packed_dpd)
    );

    // Group-fill state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= EMPTY;
        else        cnt <= cnt_next;
    end

    // Advance the fill count on each accepted digit; a closed group returns to EMPTY.
    always_comb begin
        cnt_next = cnt;
        if (accept) begin
            if (grp_done) begin
                cnt_next = EMPTY;
            end else begin
                case (cnt)
                    EMPTY:   cnt_next = ONE;
                    ONE:     cnt_next = TWO;
                    default: cnt_next = EMPTY;
                endcase
            end
        end
    end

    // Handshake and group-close decode; dig_data only matters when accepted.
    always_comb begin
        dig_ready   = !dec_valid || dec_ready;
        accept      = dig_valid && dig_ready;
        grp_done    = accept && ((cnt == TWO) || dig_last);
        grp_err_all = grp_err || (dig_data > MAX_DIGIT);
    end

    // Digit shift register and per-group error flag; cleared when a group closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s0      <= '0;
            grp_err <= 1'b0;
        end else if (accept) begin
            if (grp_done) begin
                s1      <= '0;
                s0      <= '0;
                grp_err <= 1'b0;
            end else begin
                s1      <= s0;
                s0      <= dig_data;
                grp_err <= grp_err_all;
            end
        end
    end

    // Declet index within the current number; saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (grp_done) begin
            if (dig_last)       idx <= '0;
            else if (idx != '1) idx <= idx + IDX_W'(1);
        end
    end

    // Output register: load on group close (even while draining), else drop valid on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid <= 1'b0;
            dec_data  <= '0;
            dec_ndig  <= '0;
            dec_last  <= 1'b0;
            dec_err   <= 1'b0;
            dec_idx   <= '0;
        end else if (grp_done) begin
            dec_valid <= 1'b1;
            dec_data  <= (ERR_ZERO && grp_err_all) ? '0 : packed_dpd;
            dec_ndig  <= 2'(cnt) + 2'd1;
            dec_last  <= dig_last;
            dec_err   <= grp_err_all;
            dec_idx   <= idx;
        end else if (dec_ready) begin
            dec_valid <= 1'b0;
        end
    end

    // Sticky error: a newly loaded bad declet wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       err_sticky <= 1'b0;
        else if (grp_done && grp_err_all) err_sticky <= 1'b1;
        else if (clr_err)                 err_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_bcd_declet_packer.sv
// Scoreboard bench for bcd_declet_packer: a reference group/DPD model queues expected
// declets as digits are accepted; a monitor pops and compares them as declets are consumed.
// A second instance with ERR_ZERO=1 runs on the same stimulus.
module tb_bcd_declet_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dig_valid;
    logic [3:0] dig_data;
    logic       dig_last;
    logic       dec_ready;
    logic       clr_err;

    logic       dig_ready,  z_dig_ready;
    logic       dec_valid,  z_dec_valid;
    logic [9:0] dec_data,   z_dec_data;
    logic [1:0] dec_ndig,   z_dec_ndig;
    logic       dec_last,   z_dec_last;
    logic       dec_err,    z_dec_err;
    logic [7:0] dec_idx,    z_dec_idx;
    logic       err_sticky, z_err_sticky;

    typedef struct {
        logic [9:0] data;
        logic [1:0] ndig;
        logic       last;
        logic       err;
        logic [7:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    logic [3:0] m_s1, m_s0;
    int         m_cnt;
    logic       m_err;
    int         m_idx;

    bcd_declet_packer #(.IDX_W(8), .ERR_ZERO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .dig_valid(dig_valid), .dig_data(dig_data), .dig_last(dig_last), .dig_ready(dig_ready),
        .dec_valid(dec_valid), .dec_data(dec_data), .dec_ndig(dec_ndig), .dec_last(dec_last),
        .dec_err(dec_err), .dec_idx(dec_idx), .dec_ready(dec_ready),
        .err_sticky(err_sticky), .clr_err(clr_err)
    );

    bcd_declet_packer #(.IDX_W(8), .ERR_ZERO(1'b1)) dut_zero (
        .clk(clk), .rst_n(rst_n),
        .dig_valid(dig_valid), .dig_data(dig_data), .dig_last(dig_last), .dig_ready(z_dig_ready),
        .dec_valid(z_dec_valid), .dec_data(z_dec_data), .dec_ndig(z_dec_ndig), .dec_last(z_dec_last),
        .dec_err(z_dec_err), .dec_idx(z_dec_idx), .dec_ready(dec_ready),
        .err_sticky(z_err_sticky), .clr_err(clr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference DPD encoder: digit = {a,b,c,d}, layout chosen by the three "a" bits.
    function automatic logic [9:0] dpd_model(input logic [3:0] x2, input logic [3:0] x1,
                                             input logic [3:0] x0);
        logic a, b, c, d, e, f, g, h, i, j, k, m;
        {a, b, c, d} = x2;
        {e, f, g, h} = x1;
        {i, j, k, m} = x0;
        case ({a, e, i})
            3'b000:  return {b, c, d, f, g, h, 1'b0, j, k, m};
            3'b001:  return {b, c, d, f, g, h, 1'b1, 1'b0, 1'b0, m};
            3'b010:  return {b, c, d, j, k, h, 1'b1, 1'b0, 1'b1, m};
            3'b011:  return {b, c, d, 1'b1, 1'b0, h, 1'b1, 1'b1, 1'b1, m};
            3'b100:  return {j, k, d, f, g, h, 1'b1, 1'b1, 1'b0, m};
            3'b101:  return {f, g, d, 1'b0, 1'b1, h, 1'b1, 1'b1, 1'b1, m};
            3'b110:  return {j, k, d, 1'b0, 1'b0, h, 1'b1, 1'b1, 1'b1, m};
            default: return {1'b0, 1'b0, d, 1'b1, 1'b1, h, 1'b1, 1'b1, 1'b1, m};
        endcase
    endfunction

    function automatic void model_clear();
        m_s1 = '0; m_s0 = '0; m_cnt = 0; m_err = 1'b0; m_idx = 0;
    endfunction

    function automatic void model_accept(input logic [3:0] d, input logic last);
        exp_t e;
        logic err;
        err = m_err | (d > 4'd9);
        if (m_cnt == 2 || last) begin
            e.data = dpd_model(m_s1, m_s0, d);
            e.ndig = 2'(m_cnt + 1);
            e.last = last;
            e.err  = err;
            e.idx  = 8'(m_idx);
            sb.push_back(e);
            m_idx = last ? 0 : ((m_idx == 255) ? 255 : m_idx + 1);
            m_s1 = '0; m_s0 = '0; m_cnt = 0; m_err = 1'b0;
        end else begin
            m_s1 = m_s0; m_s0 = d; m_cnt++; m_err = err;
        end
    endfunction

    // Consume-side monitor: a declet offered and taken at the next edge is compared here.
    always @(negedge clk) begin
        if (rst_n && dec_valid && dec_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dec_data", 32'(dec_data), 32'(e.data));
                chk("dec_ndig", 32'(dec_ndig), 32'(e.ndig));
                chk("dec_last", 32'(dec_last), 32'(e.last));
                chk("dec_err",  32'(dec_err),  32'(e.err));
                chk("dec_idx",  32'(dec_idx),  32'(e.idx));
                chk("zero_valid", 32'(z_dec_valid), 32'd1);
                chk("zero_data", 32'(z_dec_data), e.err ? 32'd0 : 32'(e.data));
            end
        end
    end

    task automatic set_idle();
        dig_valid = 1'b0;
        dig_data  = 4'hF;
        dig_last  = 1'b1;
    endtask

    // Offer one digit from posedge+1; returns at posedge+1 after it is accepted.
    task automatic send_digit(input logic [3:0] d, input logic last);
        int n = 0;
        dig_valid = 1'b1;
        dig_data  = d;
        dig_last  = last;
        @(negedge clk);
        while (!dig_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!dig_ready) chk("dig_timeout", 32'd0, 32'd1);
        else            model_accept(d, last);
        @(posedge clk); #1;
        set_idle();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_data",  32'(dec_data),  32'd0);
        chk("rst_dec_ndig",  32'(dec_ndig),  32'd0);
        chk("rst_dec_last",  32'(dec_last),  32'd0);
        chk("rst_dec_err",   32'(dec_err),   32'd0);
        chk("rst_dec_idx",   32'(dec_idx),   32'd0);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
        chk("rst_dig_ready", 32'(dig_ready), 32'd1);
        sb.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int c0;
        int n;
        rst_n = 1'b0;
        dec_ready = 1'b1;
        clr_err = 1'b0;
        set_idle();
        model_clear();
        #12;
        chk("init_dec_valid", 32'(dec_valid), 32'd0);
        chk("init_err_sticky", 32'(err_sticky), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("init_dig_ready", 32'(dig_ready), 32'd1);

        // 1: one full group
        send_digit(4'd1, 1'b0); send_digit(4'd2, 1'b0); send_digit(4'd3, 1'b1);
        chk("t1_valid", 32'(dec_valid), 32'd1);
        chk("t1_data", 32'(dec_data), 32'h0A3);
        idle_cycles(2);

        // 2: two groups streamed on consecutive cycles
        c0 = cyc;
        send_digit(4'd9, 1'b0); send_digit(4'd9, 1'b0); send_digit(4'd9, 1'b0);
        chk("t2_first", 32'(dec_data), 32'h0FF);
        send_digit(4'd1, 1'b0); send_digit(4'd2, 1'b0); send_digit(4'd3, 1'b1);
        chk("t2_cycles", 32'(cyc - c0), 32'd6);
        chk("t2_second", 32'(dec_data), 32'h0A3);
        idle_cycles(2);

        // 3: short final group, then a fresh number restarts idx
        send_digit(4'd4, 1'b0); send_digit(4'd5, 1'b1);
        chk("t3_data", 32'(dec_data), 32'h045);
        chk("t3_ndig", 32'(dec_ndig), 32'd2);
        send_digit(4'd6, 1'b0); send_digit(4'd7, 1'b0); send_digit(4'd8, 1'b1);
        chk("t3_idx", 32'(dec_idx), 32'd0);
        idle_cycles(2);

        // 4: invalid digit, sticky error, clear, and set-wins-over-clear
        send_digit(4'd1, 1'b0); send_digit(4'hA, 1'b0); send_digit(4'd3, 1'b1);
        chk("t4_sticky", 32'(err_sticky), 32'd1);
        chk("t4_zero_data", 32'(z_dec_data), 32'd0);
        clr_err = 1'b1;
        idle_cycles(1);
        clr_err = 1'b0;
        chk("t4_cleared", 32'(err_sticky), 32'd0);
        clr_err = 1'b1;
        send_digit(4'hB, 1'b0); send_digit(4'd2, 1'b1);
        clr_err = 1'b0;
        chk("t4_set_wins", 32'(err_sticky), 32'd1);
        idle_cycles(2);

        // 5: backpressure holds the register; raising ready drains and reloads on one edge
        dec_ready = 1'b0;
        send_digit(4'd1, 1'b0); send_digit(4'd2, 1'b0); send_digit(4'd3, 1'b1);
        dig_valid = 1'b1; dig_data = 4'd6; dig_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_dig_ready", 32'(dig_ready), 32'd0);
            chk("t5_hold_valid", 32'(dec_valid), 32'd1);
            chk("t5_hold_data", 32'(dec_data), 32'h0A3);
        end
        @(posedge clk); #1;
        dec_ready = 1'b1;
        @(negedge clk);
        chk("t5_ready_up", 32'(dig_ready), 32'd1);
        if (dig_ready) model_accept(4'd6, 1'b1);
        @(posedge clk); #1;
        set_idle();
        chk("t5_reload_valid", 32'(dec_valid), 32'd1);
        chk("t5_reload_data", 32'(dec_data), 32'h006);
        idle_cycles(2);

        // idx saturation: 258 groups in one number, then a closing group
        for (int k = 0; k < 258 * 3; k++) send_digit(4'd0, 1'b0);
        chk("sat_idx_run", 32'(dec_idx), 32'd255);
        send_digit(4'd0, 1'b1);
        chk("sat_idx_last", 32'(dec_idx), 32'd255);
        idle_cycles(2);

        // 6: async reset with an erroneous declet pending, then mid-group
        dec_ready = 1'b0;
        send_digit(4'd1, 1'b0); send_digit(4'hA, 1'b0); send_digit(4'd3, 1'b1);
        chk("t6_pending", 32'(dec_valid), 32'd1);
        async_reset();
        dec_ready = 1'b1;
        send_digit(4'd1, 1'b0); send_digit(4'd2, 1'b0);
        async_reset();
        send_digit(4'd7, 1'b0); send_digit(4'd8, 1'b0); send_digit(4'd9, 1'b1);
        chk("t6_data", 32'(dec_data), 32'h3CF);
        chk("t6_idx", 32'(dec_idx), 32'd0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            n++;
            @(posedge clk);
        end
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        idle_cycles(1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
